// File: rtl/pipe_ctrl.sv
// Pipeline control: per-lane stall vectors, exception/return flush-redirect
// sequencing with a valid/ready handshake to fetch, and entry/return address registers.
module pipe_ctrl #(
  parameter int unsigned       STAGES       = 7,
  parameter int unsigned       LANES        = 2,
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       FLUSH_CYCLES = 2,
  parameter bit                COUPLED      = 1'b1,
  parameter logic [ADDR_W-1:0] RESET_VEC    = 32'h0000000c
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES*STAGES-1:0]   stallreq_i,
  input  logic                      excp_valid_i,
  input  logic [ADDR_W-1:0]         excp_pc_i,
  input  logic                      ertn_i,
  input  logic                      eentry_we_i,
  input  logic [ADDR_W-1:0]         eentry_wdata_i,
  output logic [LANES*STAGES-1:0]   stall_o,
  output logic [STAGES-1:0]         flush_o,
  output logic                      redirect_valid_o,
  output logic [ADDR_W-1:0]         redirect_pc_o,
  input  logic                      redirect_ready_i,
  output logic [ADDR_W-1:0]         era_o,
  output logic                      busy_o
);

  localparam int unsigned       CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]               target_q, eentry_q, era_q;
  logic                            capture_excp, capture_ertn;

  logic [LANES-1:0][STAGES-1:0]    req_v, lane_stall, idle_stall, stall_v;
  logic [STAGES-1:0]               any_stall;

  assign req_v = stallreq_i;

  // Suffix-OR from the top stage down: a request at stage k stalls stages 0..k.
  always_comb begin
    lane_stall = '0;
    any_stall  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_stall[l][STAGES-1] = req_v[l][STAGES-1];
      for (int unsigned s = STAGES - 1; s > 0; s--) begin
        lane_stall[l][s-1] = lane_stall[l][s] | req_v[l][s-1];
      end
      any_stall = any_stall | lane_stall[l];
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      idle_stall[l] = COUPLED ? any_stall : lane_stall[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    stall_v          = '0;
    flush_o          = '0;
    redirect_valid_o = 1'b0;
    capture_excp     = 1'b0;
    capture_ertn     = 1'b0;
    case (state_q)
      IDLE: begin
        stall_v = idle_stall;
        if (excp_valid_i) begin
          capture_excp = 1'b1;
          state_d      = FLUSH;
          cnt_d        = CNT_LOAD;
        end else if (ertn_i) begin
          capture_ertn = 1'b1;
          state_d      = FLUSH;
          cnt_d        = CNT_LOAD;
        end
      end
      FLUSH: begin
        flush_o = '1;
        if (cnt_q == '0) begin
          state_d = REDIRECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        for (int unsigned l = 0; l < LANES; l++) begin
          stall_v[l][0] = 1'b1;
        end
        if (redirect_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // target_q only moves on capture, so it holds while fetch back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      era_q    <= '0;
      target_q <= '0;
    end else if (capture_excp) begin
      era_q    <= excp_pc_i;
      target_q <= eentry_q;
    end else if (capture_ertn) begin
      target_q <= era_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eentry_q <= RESET_VEC;
    end else if (eentry_we_i) begin
      eentry_q <= eentry_wdata_i;
    end
  end

  assign stall_o       = stall_v;
  assign redirect_pc_o = target_q;
  assign era_o         = era_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the multi-lane in-order core. It turns per-lane, per-stage stall requests into per-lane stall vectors, with optional lock-step coupling across lanes. It sequences exception and exception-return redirects through a registered flush/redirect state machine with a valid/ready handshake to fetch. It holds the exception entry base and return address registers.

## Interface
Parameters:
- STAGES, 7: pipeline stages per lane; stage 0 = PC/fetch, stage STAGES-1 = writeback.
- LANES, 2: issue lanes.
- ADDR_W, 32: PC width.
- FLUSH_CYCLES, 2: cycles flush_o is held per redirect, ≥1.
- COUPLED, 1: 1 = any lane's stall stalls all lanes; 0 = lanes stall independently.
- RESET_VEC, 32'h0000000c: reset value of the entry base.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- stallreq_i  in  LANES*STAGES  bit l*STAGES+s = lane l, stage s requests stall.
- excp_valid_i  in  1  committing instruction raised an exception.
- excp_pc_i  in  ADDR_W  PC of the excepting instruction.
- ertn_i  in  1  exception-return committing.
- eentry_we_i  in  1  write entry base.
- eentry_wdata_i  in  ADDR_W  new entry base.
- stall_o  out  LANES*STAGES  per-lane per-stage stall, same bit layout as stallreq_i.
- flush_o  out  STAGES  flush all lanes of stage s.
- redirect_valid_o  out  1  redirect offered to fetch.
- redirect_pc_o  out  ADDR_W  redirect target.
- redirect_ready_i  in  1  fetch accepts redirect.
- era_o  out  ADDR_W  exception return address register.
- busy_o  out  1  state ≠ IDLE.

## Operation
- Registers: state {IDLE, FLUSH, REDIRECT}, flush counter (clog2(FLUSH_CYCLES+1) bits), target_q, eentry_q, era_q.
- Stall generation (combinational, IDLE only): a request at lane l, stage k sets stall bits 0..k of lane l. Multiple requests OR together, so the highest requesting stage dominates. COUPLED=1: OR the per-lane vectors and drive the result on every lane.
- IDLE:
  - excp_valid_i=1: era_q←excp_pc_i; target_q←eentry_q, using the pre-write value if eentry_we_i is in the same cycle; go to FLUSH.
  - else ertn_i=1: target_q←era_q; go to FLUSH.
  - excp_valid_i has priority over ertn_i.
- FLUSH: flush_o all ones, stall_o all zero. The counter loads FLUSH_CYCLES-1 on entry and decrements. At 0, go to REDIRECT.
- REDIRECT:
  - redirect_valid_o=1, redirect_pc_o=target_q. Stage 0 of every lane is stalled; all other stall bits are 0; flush_o=0.
  - Go to IDLE on the cycle redirect_valid_o && redirect_ready_i.
  - target_q must stay stable while valid && !ready.
- excp_valid_i and ertn_i are ignored outside IDLE; the pipeline is being flushed.
- eentry_we_i takes effect in any state. eentry_q updates on the next edge.
- Outputs: era_o=era_q. busy_o=(state≠IDLE). redirect_pc_o=target_q in all states.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, eentry_q=RESET_VEC, era_q=0, target_q=0. Resulting outputs: stall_o=0, flush_o=0, redirect_valid_o=0, redirect_pc_o=0, era_o=0, busy_o=0.
- Reset mid-FLUSH or mid-REDIRECT returns to IDLE immediately. The redirect is dropped.
- Stall latency: 0 cycles, combinational from stallreq_i, in IDLE.
- Exception sampled at edge T: flush_o=all ones in cycles T+1 .. T+FLUSH_CYCLES; redirect_valid_o=1 from cycle T+FLUSH_CYCLES+1.
- With ready already high, the minimum exception-to-IDLE time is FLUSH_CYCLES+1 cycles.
- Stall requests in FLUSH/REDIRECT are masked as specified; they reapply combinationally once back in IDLE.
- A new exception may be accepted in the first IDLE cycle after the handshake.

## Test plan
- Stall mapping, COUPLED=1, LANES=2, STAGES=7: stallreq_i bit 4 (lane 0, stage 4) -> stall_o = 7'b0011111 on both lanes, same cycle. Same stimulus with COUPLED=0 -> lane 1 stall = 0.
- Exception, FLUSH_CYCLES=2: excp_valid_i=1, excp_pc_i=32'h1C000100, ready tied high -> flush_o=7'h7F for 2 cycles; then redirect_valid_o=1 with pc=32'h0000000c for 1 cycle; era_o=32'h1C000100; busy_o drops after 3 cycles.
- Back-pressure: hold redirect_ready_i=0 for 5 cycles in REDIRECT -> redirect_valid_o and pc stable, stage-0 stall bits =1, excp_valid_i pulses ignored; then ready=1 -> IDLE next cycle.
- Entry write and return:
  - eentry_we_i with 32'h1C008000 in the same cycle as an exception -> redirect target 32'h0000000c.
  - Next exception -> target 32'h1C008000.
  - ertn_i -> redirect to era_o.
- Priority: excp_valid_i and ertn_i in the same cycle -> exception path taken, era_q updated.
- Reset mid-REDIRECT: drop rst_n -> all outputs 0 asynchronously, eentry_q back to 32'h0000000c.
